// File: rtl/mem_bwe_pipe_if.sv
// Bus interface for mem_bwe_pipe: write port with byte enables, read request
// port, and read response / status signals.
// With MEM_PARITY_EN defined the interface also carries par_inj and par_err.
interface mem_bwe_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  wr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NBYTES-1:0]     wbe;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  busy;
`ifdef MEM_PARITY_EN
  logic                  par_inj;
  logic                  par_err;

  modport master (
    output wr, waddr, wdata, wbe, rd, raddr, par_inj,
    input  rdata, rvalid, busy, par_err
  );

  modport slave (
    input  wr, waddr, wdata, wbe, rd, raddr, par_inj,
    output rdata, rvalid, busy, par_err
  );
`else
  modport master (
    output wr, waddr, wdata, wbe, rd, raddr,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  wr, waddr, wdata, wbe, rd, raddr,
    output rdata, rvalid, busy
  );
`endif
endinterface

// File: rtl/mem_bwe_pipe.sv
// mem_bwe_pipe: simple-dual-port synchronous RAM. It has one byte-enabled
// write port and one read port with a RD_LATENCY-deep (1..3) pipelined
// response and rvalid.
// After reset an INIT sweep zeroes every word. During the sweep busy is high
// and all requests are dropped.
// BYPASS=1 forwards enabled write bytes to a same-cycle same-address read.
// BYPASS=0 returns the old word for such a read.
// Optional feature macro: MEM_PARITY_EN. It adds one even-parity bit per byte,
// the par_inj fault-injection input and the par_err read flag.
module mem_bwe_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_bwe_pipe_if.slave bus
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned LAT    = RD_LATENCY;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  busy;
  logic                  rd_go;
  logic                  collide;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  logic [LAT-1:0]        vld_q;
  logic [DATA_WIDTH-1:0] dat_q [LAT];

`ifdef MEM_PARITY_EN
  logic [NBYTES-1:0]     mem_par [DEPTH];
  logic [NBYTES-1:0]     wpar;
  logic [NBYTES-1:0]     rd_par;
  logic                  rd_err;
  logic [LAT-1:0]        err_q;
`endif

  // State register and clear pointer; the pointer wraps back to 0 when the sweep ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  // Next-state logic; busy stays high until the last word has been cleared
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      INIT: begin
        if (clr_ptr == '1) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b0;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign rd_go   = ~busy & bus.rd;
  assign collide = (BYPASS != 0) && bus.wr && (bus.waddr == bus.raddr);

`ifdef MEM_PARITY_EN
  // Parity bits as they will be stored; par_inj flips the bits of the enabled bytes
  always_comb begin
    wpar = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      wpar[i] = (^bus.wdata[8*i +: 8]) ^ bus.par_inj;
    end
  end
`endif

  // Array update: zero fill during the INIT sweep, byte-enabled writes in RUN
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_ptr] <= '0;
`ifdef MEM_PARITY_EN
      mem_par[clr_ptr] <= '0;
`endif
    end else if (bus.wr) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (bus.wbe[i]) begin
          mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
`ifdef MEM_PARITY_EN
          mem_par[bus.waddr][i] <= wpar[i];
`endif
        end
      end
    end
  end

  // Read word as of this cycle; a colliding write overrides only its enabled bytes
  always_comb begin
    rd_word = mem[bus.raddr];
`ifdef MEM_PARITY_EN
    rd_par  = mem_par[bus.raddr];
`endif
    if (collide) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (bus.wbe[i]) begin
          rd_word[8*i +: 8] = bus.wdata[8*i +: 8];
`ifdef MEM_PARITY_EN
          rd_par[i] = wpar[i];
`endif
        end
      end
    end
  end

`ifdef MEM_PARITY_EN
  // Even parity check across all bytes of the word being read
  always_comb begin
    rd_err = 1'b0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      rd_err = rd_err | ((^rd_word[8*i +: 8]) ^ rd_par[i]);
    end
  end
`endif

  // Read pipeline. Stage payloads load only behind a valid, so the last stage
  // (rdata) keeps its value between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        dat_q[k] <= '0;
      end
`ifdef MEM_PARITY_EN
      err_q <= '0;
`endif
    end else begin
      vld_q[0] <= rd_go;
      if (rd_go) begin
        dat_q[0] <= rd_word;
`ifdef MEM_PARITY_EN
        err_q[0] <= rd_err;
`endif
      end
      for (int unsigned k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          dat_q[k] <= dat_q[k-1];
`ifdef MEM_PARITY_EN
          err_q[k] <= err_q[k-1];
`endif
        end
      end
    end
  end

  assign bus.rdata  = dat_q[LAT-1];
  assign bus.rvalid = vld_q[LAT-1];
  assign bus.busy   = busy;
`ifdef MEM_PARITY_EN
  assign bus.par_err = err_q[LAT-1];
`endif

endmodule
